p23_div_responder: RTL and testbench
====================================

// Module: p23_div_responder
// PURPOSE
//  Multicycle radix-2 restoring divider. It is the responder on the div_valid/div_ready
//  handshake that the core control unit drives for RV32M DIV/DIVU/REM/REMU.
//  - Operands come from the rs1/rs2 datapath registers.
//  - The result returns to the register-file write mux.
//  - One quotient bit is produced per cycle.
//  - The RISC-V divide-by-zero and signed-overflow results come out on a fast path.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//  clk         in   1      core clock; all state updates on the rising edge
//  resetn      in   1      asynchronous, active-low reset
//  div_valid   in   1      request from control FSM, held high until div_ready is seen
//  div_op      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (= funct3[1:0])
//  dividend    in   WIDTH  rs1 value
//  divisor     in   WIDTH  rs2 value
//  div_ready   out  1      one-cycle completion pulse; registered
//  div_result  out  WIDTH  quotient or remainder; registered, stable from div_ready until next accept
//  div_busy    out  1      high in CALC, READY and DRAIN
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - state=IDLE; div_ready=0, div_result=0, div_busy=0; all internal registers 0.
//  States:
//   - IDLE: on div_valid=1, capture div_op and operands, then take exactly one path.
//     * Divisor==0: result = all-ones (DIV/DIVU) or dividend (REM/REMU); go to READY.
//     * Signed op with dividend=0x8000_0000 and divisor=-1: result = 0x8000_0000 (DIV) or 0 (REM); go to READY.
//     * Otherwise: load |dividend|, |divisor|; take absolute values only for signed ops. Record the negate flags. Counter=WIDTH; go to CALC.
//   - CALC: one shift/trial-subtract step per cycle; counter decrements.
//     * Partial remainder is WIDTH+1 bits; quotient bit = !borrow.
//     * When counter reaches 1, the final step executes. Result is muxed in:
//       quotient, negated if signed and operand signs differ; or
//       remainder, negated if signed and dividend negative.
//     * Then go to READY.
//   - READY: div_ready=1 for exactly this cycle; go to DRAIN.
//   - DRAIN: stay until div_valid=0, then go to IDLE.
//     The FSM holds valid during the ready cycle; DRAIN prevents re-triggering on a stale request.
//  Latency (cycle 0 = the edge at which IDLE samples div_valid=1):
//   - Normal: div_ready high in cycle WIDTH+1 (33 for WIDTH=32).
//   - Fast path: div_ready high in cycle 1.
//  Operand/op inputs are sampled only in IDLE; later changes are ignored.
//  div_valid dropping during CALC aborts to IDLE. No div_ready is issued; div_result keeps its old value.
//  Back-to-back: a new request is accepted no earlier than the first IDLE cycle after div_valid was low for 1 cycle.
//  resetn asserted in any state aborts immediately; no div_ready is issued after release until a new request.
// TESTING
//  1. DIVU 100/7 -> div_ready at cycle 33, div_result=14; REMU same operands -> 2.
//  2. DIV 0xFFFF_FFF9 (-7) / 2 -> 0xFFFF_FFFD (-3); REM -> 0xFFFF_FFFF (-1); REM 7/-2 -> 1.
//  3. DIVU 0x1234/0 -> 0xFFFF_FFFF at cycle 1; REM 0x1234/0 -> 0x1234 at cycle 1.
//  4. DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000, cycle 1; REM same operands -> 0.
//  5. Hold div_valid 3 cycles past div_ready -> single pulse only. Then drop valid 1 cycle and re-request -> second result correct.
//  6. Pull resetn low at cycle 10 of CALC -> outputs 0 immediately, no div_ready. Then DIVU 0xFFFF_FFFF/1 -> 0xFFFF_FFFF.

Source files
------------

// File: rtl/p23_div_responder.sv
// Multicycle radix-2 restoring divider answering the core's div_valid/div_ready handshake
// for DIV/DIVU/REM/REMU. Divide-by-zero and signed overflow resolve without iterating.
module p23_div_responder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_ready,
  output logic [WIDTH-1:0] div_result,
  output logic             div_busy
);

  // state   | meaning
  // S_IDLE  | waiting for a request; operands and op sampled here only
  // S_CALC  | one quotient bit per cycle, counter runs WIDTH..1
  // S_READY | result settled; div_ready pulses on leaving this state
  // S_DRAIN | waiting for the requester to drop div_valid
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_READY, S_DRAIN} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_nxt;

  logic             op_rem, q_neg, r_neg;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo, dvsr;
  logic [CW-1:0]    count;

  logic             load, fast, step;
  logic             signed_op, a_neg, b_neg, div_zero, overflow;
  logic [WIDTH-1:0] abs_a, abs_b, fast_val, final_val;
  logic [WIDTH:0]   shifted, rem_nxt;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] quo_nxt;
  logic             borrow;
  logic             unused_bits;

  assign signed_op = ~div_op[0];
  assign a_neg     = signed_op & dividend[WIDTH-1];
  assign b_neg     = signed_op & divisor[WIDTH-1];
  assign abs_a     = a_neg ? -dividend : dividend;
  assign abs_b     = b_neg ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  always_comb begin
    fast_val = '0;
    if (div_zero) fast_val = div_op[1] ? dividend : '1;
    else if (!div_op[1]) fast_val = {1'b1, {(WIDTH-1){1'b0}}};
  end

  // Trial subtract on a WIDTH+1 bit partial remainder; the extra top bit is the borrow.
  assign shifted   = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign trial     = {1'b0, shifted} - {2'b00, dvsr};
  assign borrow    = trial[WIDTH+1];
  assign rem_nxt   = borrow ? shifted : trial[WIDTH:0];
  assign quo_nxt   = {quo[WIDTH-2:0], ~borrow};
  assign final_val = op_rem ? (r_neg ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0])
                            : (q_neg ? -quo_nxt : quo_nxt);
  assign unused_bits = rem[WIDTH] ^ rem_nxt[WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fast      = 1'b0;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        if (div_valid) begin
          if (div_zero || overflow) begin
            fast      = 1'b1;
            state_nxt = S_READY;
          end else begin
            load      = 1'b1;
            state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!div_valid) begin
          state_nxt = S_IDLE;
        end else begin
          step = 1'b1;
          if (count == CW'(1)) state_nxt = S_READY;
        end
      end
      S_READY: state_nxt = S_DRAIN;
      S_DRAIN: if (!div_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_rem     <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      count      <= '0;
      div_result <= '0;
      div_ready  <= 1'b0;
    end else begin
      div_ready <= (state == S_READY);
      if (load) begin
        op_rem <= div_op[1];
        q_neg  <= a_neg ^ b_neg;
        r_neg  <= a_neg;
        rem    <= '0;
        quo    <= abs_a;
        dvsr   <= abs_b;
        count  <= CW'(WIDTH);
      end
      if (fast) div_result <= fast_val;
      if (step) begin
        rem   <= rem_nxt;
        quo   <= quo_nxt;
        count <= count - 1'b1;
        if (count == CW'(1)) div_result <= final_val;
      end
    end
  end

  assign div_busy = (state != S_IDLE);

endmodule

// File: tb/tb_p23_div_responder.sv
// Randomized and directed bench for p23_div_responder against an arithmetic RV32M model.
module tb_p23_div_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic [1:0]  div_op;
  logic [31:0] dividend, divisor;
  logic        div_ready;
  logic [31:0] div_result;
  logic        div_busy;

  int n_vec = 0;
  int n_bad = 0;

  p23_div_responder #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .div_valid(div_valid), .div_op(div_op),
    .dividend(dividend), .divisor(divisor), .div_ready(div_ready),
    .div_result(div_result), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = signed'(a);
    sb = signed'(b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns in the same phase, idle again.
  task automatic run_req(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat;
    exp = ref_div(op, a, b);
    div_op = op; dividend = a; divisor = b; div_valid = 1'b1;
    @(posedge clk); #1;
    div_op = 2'($urandom); dividend = $urandom; divisor = $urandom;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (div_ready) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(ref_lat(op, a, b)));
    check({tag, " result"}, div_result, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold ready"}, {31'b0, div_ready}, 32'h0);
      check({tag, " hold busy"}, {31'b0, div_busy}, 32'h1);
    end
    div_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, " post ready"}, {31'b0, div_ready}, 32'h0);
    check({tag, " stable"}, div_result, exp);
  endtask

  initial begin
    logic [31:0] a, b, last;
    logic [1:0]  op;
    resetn = 1'b0; div_valid = 1'b0; div_op = 2'b00; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {31'b0, div_ready}, 32'h0);
    check("reset result", div_result, 32'h0);
    check("reset busy", {31'b0, div_busy}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_req("divu 100/7", 2'b01, 32'd100, 32'd7, 0);
    run_req("remu 100/7", 2'b11, 32'd100, 32'd7, 0);
    run_req("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    run_req("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_req("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);
    run_req("divu by 0", 2'b01, 32'h1234, 32'h0, 0);
    run_req("rem by 0", 2'b10, 32'h1234, 32'h0, 0);
    run_req("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_req("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_req("divu ovf pat", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_req("hold3", 2'b00, 32'd1000, 32'hFFFF_FFFD, 3);
    run_req("after hold", 2'b11, 32'hDEAD_BEEF, 32'd97, 0);

    // Abort: dropping valid mid-calculation must leave the old result and no pulse.
    last = ref_div(2'b11, 32'hDEAD_BEEF, 32'd97);
    div_op = 2'b01; dividend = 32'd5000; divisor = 32'd3; div_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    div_valid = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (div_ready) pulses++;
      end
      check("abort pulses", 32'(pulses), 32'h0);
    end
    check("abort result", div_result, last);
    check("abort busy", {31'b0, div_busy}, 32'h0);

    // Reset at cycle 10 of CALC.
    div_op = 2'b01; dividend = 32'd123456; divisor = 32'd11; div_valid = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    resetn = 1'b0;
    div_valid = 1'b0;
    #1;
    check("rst ready", {31'b0, div_ready}, 32'h0);
    check("rst result", div_result, 32'h0);
    check("rst busy", {31'b0, div_busy}, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (div_ready) pulses++;
      end
      check("rst no pulse", 32'(pulses), 32'h0);
    end
    run_req("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 0);

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'($urandom_range(1, 20));
        1:       b = 32'h0;
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_req("random", op, a, b, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
